// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator.
//
// A clock divider produces one pixel period every CLK_DIV clk cycles. A
// horizontal counter (h) steps once per pixel period. A vertical counter (v)
// steps when h wraps. The sync pulses are registered and are computed from
// the next-state counts, so they change on the same edge as x/y.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high while (x, y) is inside the visible area
//   p_tick     out  high on the last clk of each pixel period
//   x          out  current pixel column (h counter)
//   y          out  current line (v counter)
//   frame_tick out  high on the last clk of each frame

module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS        = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             pix_last;
    logic             h_last;
    logic             v_last;

    always_comb begin
        pix_last = (div_q == DIV_LAST);
        h_last   = (h_q == H_LAST);
        v_last   = (v_q == V_LAST);

        div_d = pix_last ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;

        if (pix_last) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Sync is decoded from the next counts so the registered pulse
        // lines up with the registered x/y it belongs to.
        hsync_d = !((h_d >= H_SYNC_FIRST) && (h_d <= H_SYNC_LAST));
        vsync_d = !((v_d >= V_SYNC_FIRST) && (v_d <= V_SYNC_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x          = h_q;
    assign y          = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign p_tick     = pix_last;
    assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_tick = pix_last && h_last && v_last;

endmodule

// File: tb/tb_vga_sync.sv
// Testbench for vga_sync. A reduced-timing instance (25 x 17 pixel frame)
// is checked every clk against a reference model through a scoreboard
// queue, and directed scenarios probe reset, sync placement, line wrap,
// frame ticks and mid-frame reset. A second instance with default
// parameters is checked for the 640x480 sync timing.

module tb_vga_sync;

    localparam int CD = 4;
    localparam int HD = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VD = 10;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = CD * HT * VT;

    logic       clk;
    logic       reset;
    logic       hsync, vsync, video_on, p_tick, frame_tick;
    logic [9:0] x, y;
    logic       d_hsync, d_vsync, d_video_on, d_p_tick, d_frame_tick;
    logic [9:0] d_x, d_y;

    int checks = 0;
    int errors = 0;

    vga_sync #(
        .CLK_DIV(CD), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .p_tick(p_tick), .x(x), .y(y),
        .frame_tick(frame_tick)
    );

    vga_sync dut_def (
        .clk(clk), .reset(reset), .hsync(d_hsync), .vsync(d_vsync),
        .video_on(d_video_on), .p_tick(d_p_tick), .x(d_x), .y(d_y),
        .frame_tick(d_frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected outputs after each edge are pushed at the
    // edge and compared at the following falling edge.
    logic [24:0] sb_q[$];
    int          m_div, m_h, m_v;
    bit          m_valid = 1'b0;

    function automatic logic [24:0] make_exp(int d, int h, int v);
        logic hs, vs, vo, pt, ft;
        hs = !(h >= HD + HF && h < HD + HF + HS);
        vs = !(v >= VD + VF && v < VD + VF + VS);
        vo = (h < HD) && (v < VD);
        pt = (d == CD - 1);
        ft = pt && (h == HT - 1) && (v == VT - 1);
        return {10'(h), 10'(v), hs, vs, vo, pt, ft};
    endfunction

    always @(posedge clk) begin : model_b
        int nd, nh, nv;
        nd = m_div; nh = m_h; nv = m_v;
        if (reset) begin
            nd = 0; nh = 0; nv = 0;
        end else if (m_valid) begin
            if (nd == CD - 1) begin
                nd = 0;
                if (nh == HT - 1) begin
                    nh = 0;
                    nv = (nv == VT - 1) ? 0 : nv + 1;
                end else begin
                    nh = nh + 1;
                end
            end else begin
                nd = nd + 1;
            end
        end
        m_div <= nd; m_h <= nh; m_v <= nv;
        if (reset || m_valid) begin
            m_valid <= 1'b1;
            sb_q.push_back(make_exp(nd, nh, nv));
        end
    end

    always @(negedge clk) begin : monitor_b
        logic [24:0] e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {x, y, hsync, vsync, video_on, p_tick, frame_tick};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t actual x=%0d y=%0d hs/vs/vo/pt/ft=%b expected x=%0d y=%0d hs/vs/vo/pt/ft=%b",
                         $time, a[24:15], a[14:5], a[4:0], e[24:15], e[14:5], e[4:0]);
            end
        end
        if (m_valid) begin
            checks++;
            if ((d_x < 10'd800) !== 1'b1 || (d_y < 10'd525) !== 1'b1 ||
                d_video_on !== ((d_x < 10'd640) && (d_y < 10'd480))) begin
                errors++;
                $display("FAIL default_bounds t=%0t actual x=%0d y=%0d video_on=%b expected x<800 y<525 video_on=%b",
                         $time, d_x, d_y, d_video_on, (d_x < 10'd640) && (d_y < 10'd480));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({x, y, hsync, vsync, video_on, p_tick, frame_tick} !== {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL reset_state actual x=%0d y=%0d hs/vs/vo/pt/ft=%b%b%b%b%b expected 0 0 11100",
                     x, y, hsync, vsync, video_on, p_tick, frame_tick);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (p_tick !== (i == 3) || x !== 10'd0) begin
                errors++;
                $display("FAIL first_p_tick clk=%0d actual p_tick=%b x=%0d expected p_tick=%b x=0",
                         i + 1, p_tick, x, i == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (x !== 10'd1 || p_tick !== 1'b0) begin
            errors++;
            $display("FAIL x_after_pixel actual x=%0d p_tick=%b expected x=1 p_tick=0", x, p_tick);
        end
    endtask

    task automatic test_hsync();
        int n;
        do_reset();
        repeat (HD * CD) @(negedge clk);
        checks++;
        if (x !== 10'(HD) || video_on !== 1'b0) begin
            errors++;
            $display("FAIL end_of_visible actual x=%0d video_on=%b expected x=%0d video_on=0", x, video_on, HD);
        end
        n = 0;
        while (hsync === 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (hsync !== 1'b0 || n != HF * CD || x !== 10'(HD + HF)) begin
            errors++;
            $display("FAIL hsync_fall actual clks=%0d x=%0d hsync=%b expected clks=%0d x=%0d hsync=0",
                     n, x, hsync, HF * CD, HD + HF);
        end
        n = 0;
        while (hsync === 1'b0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (hsync !== 1'b1 || n != HS * CD || x !== 10'(HD + HF + HS)) begin
            errors++;
            $display("FAIL hsync_width actual clks=%0d x=%0d expected clks=%0d x=%0d",
                     n, x, HS * CD, HD + HF + HS);
        end
    endtask

    task automatic test_line_wrap();
        int n = 0;
        while (!(x == 10'(HT - 1) && p_tick === 1'b1) && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (x !== 10'(HT - 1) || y !== 10'd0 || p_tick !== 1'b1) begin
            errors++;
            $display("FAIL line_end_reach actual x=%0d y=%0d expected x=%0d y=0", x, y, HT - 1);
        end
        @(negedge clk);
        checks++;
        if (x !== 10'd0 || y !== 10'd1 || video_on !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap actual x=%0d y=%0d video_on=%b expected x=0 y=1 video_on=1", x, y, video_on);
        end
    endtask

    task automatic test_frames();
        int nft = 0, t1 = -1, t2 = -1, low0 = 0, low1 = 0, yfall = -1;
        do_reset();
        for (int k = 1; k <= 2 * FRAME + 100; k++) begin
            @(negedge clk);
            if (vsync === 1'b0) begin
                if (yfall < 0) yfall = int'(y);
                if (nft == 0) low0++;
                else if (nft == 1) low1++;
            end
            if (frame_tick === 1'b1) begin
                nft++;
                if (nft == 1) t1 = k;
                if (nft == 2) t2 = k;
            end
        end
        checks++;
        if (nft != 2 || t1 != FRAME - 1 || t2 - t1 != FRAME) begin
            errors++;
            $display("FAIL frame_tick actual count=%0d first=%0d gap=%0d expected count=2 first=%0d gap=%0d",
                     nft, t1, t2 - t1, FRAME - 1, FRAME);
        end
        checks++;
        if (low0 != VS * HT * CD || low1 != VS * HT * CD || yfall != VD + VF) begin
            errors++;
            $display("FAIL vsync_width actual low=%0d,%0d start_y=%0d expected low=%0d start_y=%0d",
                     low0, low1, yfall, VS * HT * CD, VD + VF);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        bit ft_seen = 1'b0;
        do_reset();
        while (!(x == 10'd12 && y == 10'd5) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (x !== 10'd12 || y !== 10'd5) begin
            errors++;
            $display("FAIL mid_reach actual x=%0d y=%0d expected x=12 y=5", x, y);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({x, y, hsync, vsync, video_on, p_tick, frame_tick} !== {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL mid_reset_state actual x=%0d y=%0d hs/vs/vo/pt/ft=%b%b%b%b%b expected 0 0 11100",
                     x, y, hsync, vsync, video_on, p_tick, frame_tick);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ft_seen = 1'b1;
            checks++;
            if (p_tick !== (i == 3)) begin
                errors++;
                $display("FAIL mid_reset_divider step=%0d actual p_tick=%b expected %b", i, p_tick, i == 3);
            end
        end
        checks++;
        if (ft_seen) begin
            errors++;
            $display("FAIL mid_reset_frame_tick actual seen=1 expected seen=0");
        end
    endtask

    task automatic test_defaults();
        int n;
        do_reset();
        checks++;
        if ({d_x, d_y, d_hsync, d_vsync, d_video_on, d_p_tick, d_frame_tick} !== {10'd0, 10'd0, 5'b11100}) begin
            errors++;
            $display("FAIL def_reset actual x=%0d y=%0d expected 0 0 with hs/vs/vo=111", d_x, d_y);
        end
        repeat (640 * 4) @(negedge clk);
        checks++;
        if (d_x !== 10'd640 || d_video_on !== 1'b0) begin
            errors++;
            $display("FAIL def_visible_end actual x=%0d video_on=%b expected x=640 video_on=0", d_x, d_video_on);
        end
        n = 0;
        while (d_hsync === 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (d_hsync !== 1'b0 || n != 64 || d_x !== 10'd656) begin
            errors++;
            $display("FAIL def_hsync_fall actual clks=%0d x=%0d expected clks=64 x=656", n, d_x);
        end
        n = 0;
        while (d_hsync === 1'b0 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (d_hsync !== 1'b1 || n != 384 || d_x !== 10'd752) begin
            errors++;
            $display("FAIL def_hsync_width actual clks=%0d x=%0d expected clks=384 x=752", n, d_x);
        end
        n = 0;
        while (!(d_x == 10'd799 && d_p_tick === 1'b1) && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd1 || d_video_on !== 1'b1) begin
            errors++;
            $display("FAIL def_line_wrap actual x=%0d y=%0d video_on=%b expected x=0 y=1 video_on=1",
                     d_x, d_y, d_video_on);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_hsync();
        test_line_wrap();
        test_frames();
        test_mid_reset();
        test_defaults();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
